// File: rtl/modrm_fetch_if.sv
// Instruction byte FIFO port bundle used by modrm_fetch.
// master = fetch side (pops bytes), slave = FIFO side.
interface modrm_fetch_if;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_rd_en
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_rd_en
  );
endinterface

// File: rtl/modrm_fetch.sv
// ModR/M + displacement fetch from the instruction byte FIFO.
// Optional MODRM_PRELOAD_EN: accept the ModR/M byte on start.
module modrm_fetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
`ifdef MODRM_PRELOAD_EN
  input  logic [7:0]  modrm_in,
  input  logic        modrm_in_valid,
`endif
  modrm_fetch_if.master fifo,
  output logic [7:0]  modrm,
  output logic [15:0] displacement,
  output logic        decode_start,
  output logic        busy,
  output logic [1:0]  byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MODRM,
    S_DISP_LO,
    S_DISP_HI,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_fetch;
  logic        w_pop;
  logic        w_pre;
  logic        w_go;
  logic [1:0]  w_base;
  logic [1:0]  r_cnt;
  logic [7:0]  r_modrm;
  logic [15:0] r_disp;
  logic        r_dstart;
  logic        r_busy;
  logic [1:0]  r_bcnt;

  function automatic logic f_has_disp(input logic [7:0] m);
    return (m[7:6] == 2'b01) ||
           (m[7:6] == 2'b10) ||
           (m[7:6] == 2'b00 && m[2:0] == 3'b110);
  endfunction

  assign w_fetch = (r_state == S_MODRM) ||
                   (r_state == S_DISP_LO) ||
                   (r_state == S_DISP_HI);
  assign w_pop   = w_fetch && !fifo.fifo_empty && !abort;
  assign w_go    = (r_state == S_IDLE) && start && !abort;
  // Counting restarts with each sequence, including preload-to-DONE.
  assign w_base  = (r_state == S_IDLE) ? 2'd0 : r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pre  = 1'b0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_next = S_MODRM;
`ifdef MODRM_PRELOAD_EN
            if (modrm_in_valid) begin
              w_pre  = 1'b1;
              w_next = f_has_disp(modrm_in) ? S_DISP_LO : S_DONE;
            end
`endif
          end
        end
        S_MODRM: begin
          if (w_pop)
            w_next = f_has_disp(fifo.fifo_data) ? S_DISP_LO : S_DONE;
        end
        S_DISP_LO: begin
          if (w_pop)
            w_next = (r_modrm[7:6] == 2'b01) ? S_DONE : S_DISP_HI;
        end
        S_DISP_HI: begin
          if (w_pop) w_next = S_DONE;
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 2'd0;
      r_modrm  <= 8'h00;
      r_disp   <= 16'h0000;
      r_dstart <= 1'b0;
      r_busy   <= 1'b0;
      r_bcnt   <= 2'd0;
    end else begin
      r_dstart <= (w_next == S_DONE);
      r_busy   <= (w_next != S_IDLE);
      if (w_go)
        r_cnt <= 2'd0;
      else if (w_pop)
        r_cnt <= r_cnt + 2'd1;
      if (w_next == S_DONE)
        r_bcnt <= w_base + {1'b0, w_pop};
`ifdef MODRM_PRELOAD_EN
      if (w_pre) begin
        r_modrm <= modrm_in;
        if (!f_has_disp(modrm_in)) r_disp <= 16'h0000;
      end
`endif
      if (w_pop) begin
        unique case (r_state)
          S_MODRM: begin
            r_modrm <= fifo.fifo_data;
            if (!f_has_disp(fifo.fifo_data)) r_disp <= 16'h0000;
          end
          S_DISP_LO: begin
            if (r_modrm[7:6] == 2'b01)
              r_disp <= {{8{fifo.fifo_data[7]}}, fifo.fifo_data};
            else
              r_disp <= {r_disp[15:8], fifo.fifo_data};
          end
          S_DISP_HI: r_disp[15:8] <= fifo.fifo_data;
          default: ;
        endcase
      end
    end
  end

  assign fifo.fifo_rd_en = w_pop;
  assign modrm           = r_modrm;
  assign displacement    = r_disp;
  assign decode_start    = r_dstart;
  assign busy            = r_busy;
  assign byte_count      = r_bcnt;

endmodule

// File: tb/tb_modrm_fetch.sv
// Directed self-checking bench for modrm_fetch.
module tb_modrm_fetch;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  modrm;
  logic [15:0] displacement;
  logic        decode_start;
  logic        busy;
  logic [1:0]  byte_count;
`ifdef MODRM_PRELOAD_EN
  logic [7:0]  modrm_in;
  logic        modrm_in_valid;
`endif

  modrm_fetch_if f ();

  modrm_fetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
`ifdef MODRM_PRELOAD_EN
    .modrm_in       (modrm_in),
    .modrm_in_valid (modrm_in_valid),
`endif
    .fifo         (f),
    .modrm        (modrm),
    .displacement (displacement),
    .decode_start (decode_start),
    .busy         (busy),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  int total  = 0;
  int passed = 0;
  int lat;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_fifo();
    f.fifo_empty = (q.size() == 0);
    f.fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic tick();
    logic rd;
    rd = f.fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd) void'(q.pop_front());
    drive_fifo();
    #1;
  endtask

  // start in cycle T; returns n where decode_start seen at T+n (0 = timeout)
  task automatic run(output int n);
    n = 0;
    start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      start = 1'b0;
      if (decode_start) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
`ifdef MODRM_PRELOAD_EN
    modrm_in       = 8'h00;
    modrm_in_valid = 1'b0;
`endif
    drive_fifo();
    repeat (3) tick();
    chk("rst_modrm", modrm, 8'h00);
    chk("rst_disp", displacement, 16'h0000);
    chk("rst_bc", byte_count, 2'd0);
    chk("rst_ds", decode_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd", f.fifo_rd_en, 1'b0);
    reset_n = 1'b1;
    tick();

    // 1-byte: mod=11
    q = '{8'hC3};
    drive_fifo();
    #1;
    run(lat);
    chk("c3_lat", lat, 2);
    chk("c3_modrm", modrm, 8'hC3);
    chk("c3_disp", displacement, 16'h0000);
    chk("c3_bc", byte_count, 2'd1);
    chk("c3_pops", q.size(), 0);
    tick();
    chk("c3_ds_once", decode_start, 1'b0);
    chk("c3_idle", busy, 1'b0);

    // disp8 sign-extended
    q = '{8'h46, 8'hFE};
    drive_fifo();
    #1;
    run(lat);
    chk("d8_lat", lat, 3);
    chk("d8_disp", displacement, 16'hFFFE);
    chk("d8_bc", byte_count, 2'd2);
    tick();

    // mod=00 rm=110 disp16
    q = '{8'h06, 8'h34, 8'h12};
    drive_fifo();
    #1;
    run(lat);
    chk("d16_lat", lat, 4);
    chk("d16_disp", displacement, 16'h1234);
    chk("d16_bc", byte_count, 2'd3);
    tick();

    // mod=10 disp16
    q = '{8'h80, 8'h10, 8'h00};
    drive_fifo();
    #1;
    run(lat);
    chk("m10_lat", lat, 4);
    chk("m10_disp", displacement, 16'h0010);
    chk("m10_modrm", modrm, 8'h80);
    tick();

    // FIFO stall: 0x86, 5 empty cycles, then FF 7F
    q = '{8'h86};
    drive_fifo();
    #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("st_rd_t1", f.fifo_rd_en, 1'b1);
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk("st_rd_empty", f.fifo_rd_en, 1'b0);
      chk("st_busy", busy, 1'b1);
      chk("st_no_ds", decode_start, 1'b0);
    end
    lat = 0;
    for (int i = 7; i <= 30; i++) begin
      tick();
      if (i == 7) begin
        q.push_back(8'hFF);
        q.push_back(8'h7F);
        drive_fifo();
        #1;
      end
      if (decode_start) begin
        lat = i;
        break;
      end
    end
    chk("st_lat", lat, 9);
    chk("st_disp", displacement, 16'h7FFF);
    chk("st_modrm", modrm, 8'h86);
    chk("st_bc", byte_count, 2'd3);
    tick();

    // abort in DISP_HI
    q = '{8'h80, 8'h11, 8'h22};
    drive_fifo();
    #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ab_hi_rd", f.fifo_rd_en, 1'b1);
    abort = 1'b1;
    #1;
    chk("ab_rd_supp", f.fifo_rd_en, 1'b0);
    tick();
    abort = 1'b0;
    #1;
    chk("ab_busy", busy, 1'b0);
    chk("ab_no_ds", decode_start, 1'b0);
    chk("ab_left", q.size(), 1);
    chk("ab_bc_kept", byte_count, 2'd3);
    tick();
    chk("ab_no_ds2", decode_start, 1'b0);
    q = '{8'h07};
    drive_fifo();
    #1;
    run(lat);
    chk("ab_next_lat", lat, 2);
    chk("ab_next_bc", byte_count, 2'd1);
    chk("ab_next_modrm", modrm, 8'h07);
    tick();

    // start while busy is ignored
    q = '{8'h06, 8'hAB};
    drive_fifo();
    #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    q.push_back(8'hCD);
    drive_fifo();
    #1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      if (decode_start) begin
        lat = i;
        break;
      end
      tick();
    end
    chk("bz_done", lat != 0, 1'b1);
    chk("bz_modrm", modrm, 8'h06);
    chk("bz_disp", displacement, 16'hCDAB);
    chk("bz_bc", byte_count, 2'd3);
    tick();

    // start with abort in IDLE
    q = '{8'h55};
    drive_fifo();
    #1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("sa_busy", busy, 1'b0);
    chk("sa_rd", f.fifo_rd_en, 1'b0);
    q.delete();
    drive_fifo();
    tick();

    // async reset mid-sequence
    q = '{8'h80, 8'h01, 8'h02};
    drive_fifo();
    #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_modrm", modrm, 8'h00);
    chk("mr_disp", displacement, 16'h0000);
    chk("mr_bc", byte_count, 2'd0);
    chk("mr_ds", decode_start, 1'b0);
    chk("mr_rd", f.fifo_rd_en, 1'b0);
    tick();
    reset_n = 1'b1;
    q.delete();
    drive_fifo();
    tick();

`ifdef MODRM_PRELOAD_EN
    q = '{8'h80};
    drive_fifo();
    modrm_in       = 8'h46;
    modrm_in_valid = 1'b1;
    #1;
    run(lat);
    modrm_in_valid = 1'b0;
    chk("pl_lat", lat, 2);
    chk("pl_disp", displacement, 16'hFF80);
    chk("pl_bc", byte_count, 2'd1);
    chk("pl_modrm", modrm, 8'h46);
    chk("pl_pops", q.size(), 0);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/modrm_fetch.md
# modrm_fetch

Front-end companion to the ModR/M address decoder. It pulls the ModR/M byte and any displacement bytes from the instruction byte FIFO. It sizes and sign-extends the displacement from the mod/rm fields. It then presents a stable `modrm` and `displacement` pair and pulses `decode_start` to launch effective-address decode. It sits between the prefetch FIFO and the decoder, and reports how many stream bytes were consumed so the IP can be advanced.

## Interface
Parameters: none.

- `clk`  input  1  core clock; all state updates on rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle request to fetch a ModR/M sequence; honoured only when idle
- `abort`  input  1  flush (branch/exception): drop the sequence in progress
- `fifo_data`  input  8  head byte of the instruction FIFO
- `fifo_empty`  input  1  FIFO has no byte available
- `fifo_rd_en`  output  1  pop head byte this cycle
- `modrm`  output  8  captured ModR/M byte, to decoder
- `displacement`  output  16  sized/sign-extended displacement, to decoder
- `decode_start`  output  1  one-cycle pulse; decoder latches `modrm`/`displacement` on it
- `busy`  output  1  sequence in progress (state != IDLE)
- `byte_count`  output  2  bytes consumed by the last completed sequence (1–3)

## Operation
- States: IDLE, MODRM, DISP_LO, DISP_HI, DONE.
- IDLE: `start`=1 → MODRM. Capture registers are held.
- MODRM: when `!fifo_empty`, pop the byte into `modrm`. Next state depends on the mod/rm fields:
  - mod=01 → DISP_LO
  - mod=10 → DISP_LO
  - mod=00 with rm=110 → DISP_LO
  - otherwise → DONE, with `displacement`=0 and `byte_count`=1
- DISP_LO: when a byte is available, pop it into the low byte.
  - mod=01: `displacement` = {8{byte[7]}, byte} → DONE, `byte_count`=2.
  - Else → DISP_HI.
- DISP_HI: when a byte is available, pop it into the high byte → DONE, `byte_count`=3.
- DONE: assert `decode_start` for exactly one cycle → IDLE.
- `fifo_rd_en` = (state ∈ {MODRM, DISP_LO, DISP_HI}) && !`fifo_empty`. It is combinational and is never asserted in IDLE or DONE. While the FIFO is empty, the state holds indefinitely.
- `abort` has priority over everything. It forces IDLE on the next edge and suppresses `fifo_rd_en` in the same cycle. No `decode_start` is issued. `modrm`, `displacement` and `byte_count` keep their last values.
- `start` outside IDLE is ignored. `start` and `abort` in the same cycle: abort wins and the machine stays in IDLE.
- Reset values: state IDLE; `modrm`=0, `displacement`=0, `byte_count`=0, `decode_start`=0, `busy`=0, `fifo_rd_en`=0.
- Reset asserted mid-sequence returns to IDLE immediately (asynchronously), with no pulse.

## Timing
- All outputs except `fifo_rd_en` are registered.
- With the FIFO never empty and `start` at cycle T:
  - MODRM at T+1.
  - `decode_start` at T+2 for a 1-byte sequence, T+3 for 2 bytes, T+4 for 3 bytes.
- Each empty cycle in a fetch state adds one cycle.
- `modrm` and `displacement` are stable from the cycle `decode_start` rises until the next sequence captures a new byte. The decoder's effective address is valid the cycle after `decode_start`.
- Back-to-back operation: `start` may be asserted in the cycle after DONE (state is IDLE).

## Configuration
- `MODRM_PRELOAD_EN` defined: adds inputs `modrm_in` (8 bits) and `modrm_in_valid` (1 bit).
  - `start` with `modrm_in_valid`=1 loads `modrm` from `modrm_in` and goes directly to DISP_LO or DONE, using the normal routing rule. The MODRM state is skipped.
  - `byte_count` then excludes the ModR/M byte, giving 0–2.
  - `start` with `modrm_in_valid`=0 behaves as normal.
- Not defined: the ports are absent and every sequence fetches ModR/M from the FIFO.

## Test plan
- FIFO holds 0xC3, `start` → one pop; `decode_start` at T+2; `modrm`=0xC3, `displacement`=0x0000, `byte_count`=1.
- FIFO holds 0x46, 0xFE → `displacement`=0xFFFE (sign-extended), `byte_count`=2, `decode_start` at T+3.
- FIFO holds 0x06, 0x34, 0x12 → `displacement`=0x1234, `byte_count`=3, `decode_start` at T+4. Also run mod=10 with 0x80, 0x10, 0x00 → `displacement`=0x0010.
- FIFO holds 0x86, then is empty for 5 cycles, then supplies 0xFF, 0x7F:
  - `fifo_rd_en` stays low while the FIFO is empty and the state holds.
  - Result: `displacement`=0x7FFF, `decode_start` at T+9.
- Abort and reset cases:
  - `abort` while in DISP_HI → IDLE next cycle, no `decode_start`, no pop that cycle, `busy`=0. A following `start` with 0x07 → `byte_count`=1.
  - `start` asserted while busy is ignored.
  - `reset_n` low mid-sequence → all outputs return to reset values.
- With `MODRM_PRELOAD_EN`: `modrm_in`=0x46, `modrm_in_valid`=1, FIFO holds 0x80 → one pop, `displacement`=0xFF80, `byte_count`=1, `decode_start` at T+2.
